// File: rtl/counter_seq_checker_pkg.sv
// Shared types and default sizes for the counter sequence checker.
package cnt_chk_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int unsigned CNT_W     = 26;
    localparam int unsigned ERR_W_DEF = 16;

endpackage

// File: rtl/counter_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment
// in the same cycle leave the counter at 1.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] base;
    logic [W-1:0] next;

    always_comb begin
        base = clr ? '0 : q;
        next = base;
        if (inc && (base != '1)) begin
            next = base + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= next;
        end
    end

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side checker for an up-counter stream: locks after a run of
// increments, then flags and counts sequence breaks.
// Optional first-error capture ports: define CNT_CHK_FIRST_ERR_EN.
module counter_seq_checker
    import cnt_chk_pkg::*;
#(
    parameter int unsigned WIDTH      = CNT_W,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_W      = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
`ifdef CNT_CHK_FIRST_ERR_EN
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_data,
    output logic [WIDTH-1:0] first_err_exp,
`endif
    output logic [WIDTH-1:0] expected
);

    state_t     state;
    logic [7:0] run;
    logic       match;
    logic       err_event;

    assign match     = (data == expected);
    assign err_event = en && (state == LOCKED) && !match;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            error    <= 1'b0;
            expected <= '0;
            run      <= '0;
        end else begin
            error <= 1'b0;
            if (en) begin
                unique case (state)
                    SEARCH: begin
                        expected <= data + WIDTH'(1);
                        run      <= '0;
                        state    <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (match) begin
                            expected <= expected + WIDTH'(1);
                            run      <= run + 8'd1;
                            if ((run + 8'd1) == 8'(LOCK_COUNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            expected <= data + WIDTH'(1);
                            run      <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            expected <= expected + WIDTH'(1);
                        end else begin
                            error    <= 1'b1;
                            expected <= data + WIDTH'(1);
                            run      <= '0;
                            state    <= ACQUIRE;
                            locked   <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_event),
        .clr   (clear),
        .q     (err_count)
    );

`ifdef CNT_CHK_FIRST_ERR_EN
    // A break coinciding with clear is taken as the first error after that clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_err_valid <= 1'b0;
            first_err_data  <= '0;
            first_err_exp   <= '0;
        end else if (err_event && (clear || !first_err_valid)) begin
            first_err_valid <= 1'b1;
            first_err_data  <= data;
            first_err_exp   <= expected;
        end else if (clear) begin
            first_err_valid <= 1'b0;
            first_err_data  <= '0;
            first_err_exp   <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_counter_seq_checker.sv
// Scoreboard bench for counter_seq_checker: directed scenarios then random traffic.
module tb_counter_seq_checker;

    localparam int unsigned W   = 26;
    localparam int unsigned LC  = 4;
    localparam int unsigned EW  = 4;
    localparam int unsigned EMX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  data;
    logic          clear;
    logic          locked;
    logic          error;
    logic [EW-1:0] err_count;
    logic [W-1:0]  expected;
`ifdef CNT_CHK_FIRST_ERR_EN
    logic          first_err_valid;
    logic [W-1:0]  first_err_data;
    logic [W-1:0]  first_err_exp;
`endif

    always #5 clk = ~clk;

    counter_seq_checker #(
        .WIDTH      (W),
        .LOCK_COUNT (LC),
        .ERR_W      (EW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .data            (data),
        .clear           (clear),
        .locked          (locked),
        .error           (error),
        .err_count       (err_count),
`ifdef CNT_CHK_FIRST_ERR_EN
        .first_err_valid (first_err_valid),
        .first_err_data  (first_err_data),
        .first_err_exp   (first_err_exp),
`endif
        .expected        (expected)
    );

    typedef struct {
        logic         lck;
        logic         err;
        int unsigned  cnt;
        logic [W-1:0] exp;
        logic         fv;
        logic [W-1:0] fd;
        logic [W-1:0] fe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: "seeded" means a previous valid sample exists,
    // "run" counts consecutive correct increments since the last seed.
    bit           m_seeded;
    bit           m_locked;
    int unsigned  m_run;
    logic [W-1:0] m_exp;
    int unsigned  m_cnt;
    bit           m_fv;
    logic [W-1:0] m_fd;
    logic [W-1:0] m_fe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [W-1:0] d, input bit c);
        exp_t x;
        bit   brk;
        @(negedge clk);
        rst_n = r; en = e; data = d; clear = c;
        brk = 1'b0;
        if (!r) begin
            m_seeded = 0; m_locked = 0; m_run = 0; m_exp = '0; m_cnt = 0;
            m_fv = 0; m_fd = '0; m_fe = '0;
        end else begin
            if (e) begin
                if (!m_seeded) begin
                    m_seeded = 1; m_run = 0; m_exp = d + 1;
                end else if (d == m_exp) begin
                    m_exp = m_exp + 1;
                    if (!m_locked) begin
                        m_run++;
                        if (m_run == LC) m_locked = 1;
                    end
                end else begin
                    if (m_locked) brk = 1'b1;
                    if (brk && (c || !m_fv)) begin
                        m_fv = 1; m_fd = d; m_fe = m_exp;
                    end
                    m_locked = 0; m_run = 0; m_exp = d + 1;
                end
            end
            if (c) m_cnt = 0;
            if (c && !brk) begin
                m_fv = 0; m_fd = '0; m_fe = '0;
            end
            if (brk && m_cnt < EMX) m_cnt++;
        end
        x.lck = m_locked; x.err = brk; x.cnt = m_cnt; x.exp = m_exp;
        x.fv = m_fv; x.fd = m_fd; x.fe = m_fe;
        sb.push_back(x);
    endtask

    task automatic run_seq(input logic [W-1:0] start, input int n);
        for (int i = 0; i < n; i++) step(1, 1, start + W'(i), 0);
    endtask

    // Monitor: outputs are valid every cycle, so one entry is retired per edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("locked", 32'(locked), 32'(x.lck));
                check("error", 32'(error), 32'(x.err));
                check("err_count", 32'(err_count), x.cnt);
                check("expected", 32'(expected), 32'(x.exp));
`ifdef CNT_CHK_FIRST_ERR_EN
                check("first_err_valid", 32'(first_err_valid), 32'(x.fv));
                check("first_err_data", 32'(first_err_data), 32'(x.fd));
                check("first_err_exp", 32'(first_err_exp), 32'(x.fe));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] top;
        top = '1;
        rst_n = 1'b0; en = 1'b0; data = '0; clear = 1'b0;

        step(0, 0, 0, 0);
        step(0, 1, 5, 1);
        // Lock from 0..4, continue to expected 10, then a break at 20 and relock at 24.
        run_seq(0, 10);
        step(1, 1, 10, 0);
        step(1, 1, 11, 0);
        run_seq(20, 5);
        step(1, 0, 0, 0);

        // Wrap through all-ones to zero.
        step(0, 0, 0, 0);
        run_seq(top - W'(2), 5);
        step(1, 0, 0, 0);

        // Gaps with garbage data while en is low.
        step(0, 0, 0, 0);
        run_seq(0, 2);
        repeat (3) step(1, 0, 99, 0);
        run_seq(2, 3);
        step(1, 0, 0, 0);

        // Three errors, then a break coinciding with clear, then clear alone.
        step(0, 0, 0, 0);
        run_seq(0, 5);
        for (int k = 1; k <= 3; k++) begin
            step(1, 1, W'(1000 * k), 0);
            run_seq(W'(1000 * k + 1), 4);
        end
        step(1, 1, 777, 1);
        run_seq(778, 4);
        step(1, 0, 0, 1);
        step(1, 1, 782, 0);

        // Two errors for first-error capture, then a one-cycle reset mid-stream.
        step(0, 0, 0, 0);
        run_seq(0, 7);
        step(1, 1, 50, 0);
        run_seq(51, 4);
        step(1, 1, 60, 0);
        run_seq(61, 2);
        step(0, 1, 63, 0);
        run_seq(100, 3);

        // Saturation: many breaks without clear.
        step(0, 0, 0, 0);
        run_seq(0, 5);
        for (int k = 0; k < 20; k++) begin
            step(1, 1, W'(5000 + 10 * k), 0);
            run_seq(W'(5001 + 10 * k), 4);
        end

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit           r, e, c;
            logic [W-1:0] d;
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 63) == 0);
            d = ($urandom_range(0, 9) == 0) ? W'($urandom) : m_exp;
            step(r, e, d, c);
        end

        step(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
